// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready handshake and a multi-cycle hold
// for one configurable control code.
module alu_ctrl_seq #(
  parameter int unsigned        FUNC_W  = 11,
  parameter int unsigned        CTRL_W  = 3,
  parameter logic [CTRL_W-1:0]  MC_CODE = CTRL_W'(3'b110),
  parameter int unsigned        MC_LAT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_control,
  output logic              illegal,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MC_LAT + 1);

  typedef enum logic [1:0] {StEmpty, StFull, StMulti} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         dec_code;
  logic               dec_ill;
  logic [CTRL_W-1:0]  dec_ctrl;
  logic               is_mc;
  logic               accept;

  // Only func[3:0] participates in decode.
  logic unused_func;
  assign unused_func = ^func[FUNC_W-1:4];

  always_comb begin
    dec_code = 3'b000;
    dec_ill  = 1'b0;
    unique case (alu_op)
      2'b00: dec_code = 3'b000;
      2'b01: dec_code = 3'b001;
      2'b11: dec_code = 3'b111;
      2'b10: begin
        case (func[3:0])
          4'b0000: dec_code = 3'b000;
          4'b0001: dec_code = 3'b001;
          4'b0010: dec_code = 3'b010;
          4'b0011: dec_code = 3'b011;
          4'b0100: dec_code = 3'b100;
          4'b0101: dec_code = 3'b101;
          4'b0110: dec_code = 3'b100;
          4'b0111: dec_code = 3'b101;
          4'b1000: dec_code = 3'b110;
          4'b1001: dec_code = 3'b110;
          default: begin
            dec_code = 3'b000;
            dec_ill  = 1'b1;
          end
        endcase
      end
      default: dec_code = 3'b000;
    endcase
  end

  assign dec_ctrl = CTRL_W'(dec_code);
  assign is_mc    = (dec_ctrl == MC_CODE) && (MC_LAT > 1) && !dec_ill;
  assign in_ready = (state_q == StEmpty) || ((state_q == StFull) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      cnt_q       <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      alu_control <= '0;
      illegal     <= 1'b0;
    end else if (accept) begin
      alu_control <= dec_ctrl;
      illegal     <= dec_ill;
      if (is_mc) begin
        state_q   <= StMulti;
        cnt_q     <= CNT_W'(MC_LAT - 1);
        out_valid <= 1'b0;
        busy      <= 1'b1;
      end else begin
        state_q   <= StFull;
        cnt_q     <= '0;
        out_valid <= 1'b1;
        busy      <= 1'b0;
      end
    end else begin
      case (state_q)
        StFull: begin
          if (out_ready) begin
            state_q   <= StEmpty;
            out_valid <= 1'b0;
          end
        end
        StMulti: begin
          // Last hold cycle: result becomes visible on this edge.
          if (cnt_q <= CNT_W'(1)) begin
            state_q   <= StFull;
            cnt_q     <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: driver pushes expected results on acceptance,
// a monitor pops and compares whenever the DUT presents or transfers an output.
module tb_alu_ctrl_seq;

  localparam int unsigned FUNC_W = 11;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned MC_LAT = 4;
  localparam int          MC_VAL = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid, in_ready, out_valid, out_ready, illegal, busy;
  logic [1:0]        alu_op;
  logic [FUNC_W-1:0] func;
  logic [CTRL_W-1:0] alu_control;

  logic              iv5, ir5, ov5, il5, bz5;
  logic [1:0]        op5;
  logic [FUNC_W-1:0] fn5;
  logic [4:0]        ac5;
  bit                busy5_seen = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(
    .FUNC_W (FUNC_W),
    .CTRL_W (CTRL_W),
    .MC_CODE(3'b110),
    .MC_LAT (MC_LAT)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .func       (func),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_control(alu_control),
    .illegal    (illegal),
    .busy       (busy)
  );

  alu_ctrl_seq #(
    .FUNC_W (FUNC_W),
    .CTRL_W (5),
    .MC_CODE(5'b00110),
    .MC_LAT (1)
  ) u_dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (iv5),
    .in_ready   (ir5),
    .alu_op     (op5),
    .func       (fn5),
    .out_valid  (ov5),
    .out_ready  (1'b1),
    .alu_control(ac5),
    .illegal    (il5),
    .busy       (bz5)
  );

  typedef struct {
    int code;
    bit ill;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   m_have_out = 1'b0;
  int   m_busy_left = 0;
  int   last_code = 0;
  bit   last_ill = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input int op, input int f4);
    int   tab[10] = '{0, 1, 2, 3, 4, 5, 4, 5, 6, 6};
    exp_t e;
    e.ill = 1'b0;
    case (op)
      0:       e.code = 0;
      1:       e.code = 1;
      3:       e.code = 7;
      default: begin
        if (f4 < 10) e.code = tab[f4];
        else begin
          e.code = 0;
          e.ill  = 1'b1;
        end
      end
    endcase
    return e;
  endfunction

  // One clock of stimulus; the model state describes what the DUT shows before the next edge.
  task automatic cycle(input bit v, input int op, input int f, input bit r, output bit acc);
    exp_t e;
    bit   exp_ready;
    @(negedge clk);
    in_valid  = v;
    alu_op    = op[1:0];
    func      = f[FUNC_W-1:0];
    out_ready = r;
    #1;
    exp_ready = (m_busy_left == 0) && (!m_have_out || r);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, m_have_out);
    check("busy", busy, m_busy_left > 0);
    acc = v && exp_ready;
    e = ref_decode(op & 3, f & 15);
    if (acc) q.push_back(e);
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_have_out = 1'b1;
    end else begin
      if (m_have_out && r) m_have_out = 1'b0;
      if (acc) begin
        if (e.code == MC_VAL && !e.ill && MC_LAT > 1) m_busy_left = MC_LAT - 1;
        else m_have_out = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_control", alu_control, 0);
    check("rst_illegal", illegal, 0);
    q.delete();
    m_have_out  = 1'b0;
    m_busy_left = 0;
    last_code   = 0;
    last_ill    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares the presented result against the scoreboard front.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (out_valid || busy) begin
        if (q.size() == 0) check("unexpected_output", 1, 0);
        else begin
          check("alu_control", alu_control, q[0].code);
          check("illegal", illegal, q[0].ill);
          if (out_valid && out_ready) begin
            last_code = q[0].code;
            last_ill  = q[0].ill;
            void'(q.pop_front());
          end
        end
      end else begin
        check("hold_alu_control", alu_control, last_code);
        check("hold_illegal", illegal, last_ill);
      end
    end
  end

  always @(negedge clk) if (bz5) busy5_seen = 1'b1;

  initial begin
    bit acc;
    int tries;
    in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; func = '0;
    iv5 = 1'b0; op5 = '0; fn5 = '0;
    do_reset();

    // func sweep under alu_op=10; multi-cycle codes stall the sweep.
    for (int f = 0; f < 16; f++) begin
      tries = 0;
      do begin
        cycle(1'b1, 2, f | ($urandom_range(0, 127) << 4), 1'b1, acc);
        tries++;
      end while (!acc && tries < 20);
      check("sweep_accept", acc, 1);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 0, 1'b1, acc);

    // Non-R-type classes with random upper func bits.
    for (int i = 0; i < 12; i++) cycle(1'b1, (i % 3 == 2) ? 3 : i % 3, $urandom, 1'b1, acc);
    cycle(1'b0, 0, 0, 1'b1, acc);

    // Multi-cycle op, then drain.
    cycle(1'b1, 2, 8, 1'b1, acc);
    for (int i = 0; i < MC_LAT + 1; i++) cycle(1'b0, 0, 0, 1'b1, acc);

    // Backpressure for 5 cycles with a pending input, then release.
    cycle(1'b1, 2, 3, 1'b1, acc);
    for (int i = 0; i < 5; i++) cycle(1'b1, 3, 0, 1'b0, acc);
    cycle(1'b1, 3, 0, 1'b1, acc);
    check("release_accept", acc, 1);
    cycle(1'b0, 0, 0, 1'b1, acc);

    // Reset during MULTI with cnt=2.
    cycle(1'b1, 2, 9, 1'b1, acc);
    cycle(1'b0, 0, 0, 1'b1, acc);
    do_reset();
    cycle(1'b0, 0, 0, 1'b1, acc);
    cycle(1'b0, 0, 0, 1'b1, acc);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom, $urandom_range(0, 9) < 7, acc);
    for (int i = 0; i < MC_LAT + 3; i++) cycle(1'b0, 0, 0, 1'b1, acc);
    check("scoreboard_drained", q.size(), 0);

    // Wide control, single-cycle latency instance.
    @(negedge clk);
    iv5 = 1'b1; op5 = 2'b10; fn5 = 11'h7f9;
    #1 check("w5_in_ready", ir5, 1);
    @(negedge clk);
    iv5 = 1'b1; op5 = 2'b11; fn5 = 11'h000;
    #1;
    check("w5_out_valid", ov5, 1);
    check("w5_alu_control", ac5, 5'b00110);
    check("w5_illegal", il5, 0);
    @(negedge clk);
    iv5 = 1'b0;
    #1;
    check("w5_alu_control_op11", ac5, 5'b00111);
    @(negedge clk);
    #1 check("w5_empty", ov5, 0);
    check("w5_busy_never", busy5_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
